// File: rtl/vram_pkg.sv
// Shared types for the VRAM write path.
// Defines the buffered write entry and the default VRAM byte-address width.
package vram_pkg;

   localparam int VRAM_ADDR_W = 19;

   typedef struct packed {
      logic [VRAM_ADDR_W-2:0] word;
      logic [15:0]            data;
      logic [1:0]             be;
   } vram_wr_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Circular write buffer for vram_write_port.
// Ports: push/push_data allocate, pop retires head, merge folds push_data
// into the newest entry; head_data/tail_data, count, full, empty report state.
module vram_wr_fifo
   import vram_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   merge,
   input  vram_wr_t               push_data,
   output vram_wr_t               head_data,
   output vram_wr_t               tail_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   vram_wr_t      mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] newest;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // A full buffer still accepts a push when the head leaves this cycle.
   assign do_push = push & (~full | do_pop);
   assign newest  = tail - 1'b1;

   assign head_data = mem[head];
   assign tail_data = mem[newest];

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + 1'b1;
         if (do_pop)  head <= head + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage carries no reset; count gates every read of it.
   always_ff @(posedge clk_sys) begin
      if (do_push) begin
         mem[tail] <= push_data;
      end else if (merge && !empty) begin
         mem[newest].be <= mem[newest].be | push_data.be;
         if (push_data.be[0])
            mem[newest].data[7:0] <= push_data.data[7:0];
         if (push_data.be[1])
            mem[newest].data[15:8] <= push_data.data[15:8];
      end
   end

endmodule

// File: rtl/vram_write_port.sv
// Buffers CPU writes to VRAM and replays them into free VRAM write slots.
// Ports: Z80 bus (cpu_addr, cpu_din, nMREQ, nWR, nRFSH, vram_sel), slot_free
// in; vram_waddr/wdata/wbe/we write port, cpu_wait and sticky overflow out.
// Build option: VRAM_WRITE_COALESCE_EN merges a byte into the newest entry.
module vram_write_port
   import vram_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = VRAM_ADDR_W
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   input  logic              nMREQ,
   input  logic              nWR,
   input  logic              nRFSH,
   input  logic              vram_sel,
   input  logic              slot_free,
   output logic [ADDR_W-2:0] vram_waddr,
   output logic [15:0]       vram_wdata,
   output logic [1:0]        vram_wbe,
   output logic              vram_we,
   output logic              cpu_wait,
   output logic              overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_WAIT = (PW+1)'(DEPTH-1);

   logic          mem_wr;
   logic          old_wr;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          merge;
   logic          full;
   logic          empty;
   logic [PW:0]   count;
   vram_wr_t      entry;
   vram_wr_t      head_data;
   vram_wr_t      tail_data;

   assign mem_wr   = ~nMREQ & ~nWR & nRFSH & vram_sel;
   // Rising edge only: one push per bus write however long it lasts.
   assign push_req = mem_wr & ~old_wr;

   always_comb begin
      entry.word = cpu_addr[ADDR_W-1:1];
      entry.data = {cpu_din, cpu_din};
      entry.be   = cpu_addr[0] ? 2'b10 : 2'b01;
   end

   assign pop = slot_free & ~empty;

`ifdef VRAM_WRITE_COALESCE_EN
   localparam logic [PW:0] CNT_ONE = (PW+1)'(1);
   // The newest entry cannot be merged while it is leaving as the head.
   assign merge = push_req & ~empty
                & (tail_data.word == entry.word)
                & ((tail_data.be & entry.be) == 2'b00)
                & ~(pop & (count == CNT_ONE));
`else
   logic unused_tail;
   assign merge       = 1'b0;
   assign unused_tail = ^tail_data;
`endif

   assign push = push_req & ~merge;

   vram_wr_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .merge     (merge),
      .push_data (entry),
      .head_data (head_data),
      .tail_data (tail_data),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   assign cpu_wait = (count >= CNT_WAIT);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         old_wr     <= 1'b0;
         vram_we    <= 1'b0;
         vram_waddr <= '0;
         vram_wdata <= '0;
         vram_wbe   <= '0;
         overflow   <= 1'b0;
      end else begin
         old_wr  <= mem_wr;
         vram_we <= pop;
         if (pop) begin
            vram_waddr <= head_data.word;
            vram_wdata <= head_data.data;
            vram_wbe   <= head_data.be;
         end
         if (push && full && !pop)
            overflow <= 1'b1;
      end
   end

endmodule
